add_exec_pipe: RTL
==================

// Module: add_exec_pipe
// PURPOSE
//  Parametrised add/logic execution unit for the Tomasulo core; successor to the fixed-delay add/sub unit.
//  Accepts one ready instruction from the add reservation stations and executes it over LATENCY cycles.
//  Presents the result on the common data bus (CDB) and holds it until the CDB arbiter grants it.
//  Supports a flush that kills the in-flight op. Reports free/busy to issue logic; no hierarchical writes.
// PARAMETERS
//  DATA_W   8   operand width
//  RES_W    16  result width (must be > DATA_W)
//  ROB_W    3   ROB index width
//  RS_W     3   reservation-station index width
//  REG_W    4   architectural register index width
//  LATENCY  4   execute cycles from accept to cdb_valid (>=1)
// PORTS
//  clk1          in   1       clock, all state updates on posedge
//  rst           in   1       synchronous active-high reset
//  issue_valid   in   1       RS presents an instruction with both operands ready
//  issue_ready   out  1       unit idle, can accept this cycle
//  func          in   4       opcode
//  rs1_data      in   DATA_W  operand 1
//  rs2_data      in   DATA_W  operand 2
//  rob_ind       in   ROB_W   destination ROB entry
//  rs_index      in   RS_W    source RS entry (freed on broadcast)
//  rd            in   REG_W   destination register
//  flush         in   1       kill in-flight op (mispredict)
//  cdb_valid     out  1       result held on CDB
//  cdb_grant     in   1       arbiter accepts broadcast this cycle
//  cdb_data      out  RES_W   result
//  cdb_rob       out  ROB_W   latched rob_ind
//  cdb_rd        out  REG_W   latched rd
//  cdb_rs        out  RS_W    latched rs_index
//  cdb_illegal   out  1       opcode was not supported
//  op_count      out  16      granted broadcasts since reset, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: state IDLE; issue_ready=1; cdb_valid=0; cdb_data/rob/rd/rs=0; cdb_illegal=0; op_count=0.
//  FSM: IDLE -> EXEC on issue_valid&issue_ready; EXEC -> WB when cycle counter reaches LATENCY-1;
//   WB -> IDLE on posedge with cdb_grant=1. issue_ready = (state==IDLE), purely registered state.
//  Accept edge latches func, operands, rob_ind, rs_index, rd; counter cleared to 0.
//  Latency: accept at edge N -> cdb_valid=1 after edge N+LATENCY. LATENCY=1 goes EXEC->WB on first EXEC edge.
//  WB holds cdb_* stable while cdb_valid=1 and cdb_grant=0 (unbounded stall allowed).
//  Grant edge: cdb_valid->0, op_count+1 (sat), IDLE; next accept earliest at following edge.
//  cdb_grant while not WB: ignored.
//  Ops (operands unsigned unless noted), result zero-extended to RES_W unless noted:
//   0000 add: {carry,sum}, DATA_W+1 bits
//   0001 sub: rs1-rs2, DATA_W+1-bit two's complement, sign-extended to RES_W
//   0010 and   0011 or   0100 xor
//   0101 slt: signed compare, result 1 or 0
//   other: cdb_data=0, cdb_illegal=1, still broadcast normally
//  Flush (sync): state->IDLE, cdb_valid->0 on that edge from any state; op_count unchanged.
//   Flush+issue_valid same edge: issue dropped. Flush+cdb_grant in WB: flush wins, no count.
//  rst overrides everything incl. mid-EXEC/WB; no partial result ever escapes.
//  Operand inputs are don't-care except on accept edge.
// TESTING
//  1 LATENCY=4, add F0+20 at edge 0 -> cdb_valid after edge 4, cdb_data=16'h0110, grant same cycle -> op_count=1.
//  2 sub 05-07 -> cdb_data=16'hFFFE; slt 80,01 -> 1; xor AA,FF -> 16'h0055; func 1111 -> data 0, cdb_illegal=1.
//  3 Hold cdb_grant=0 for 10 cycles in WB -> cdb_* stable, issue_ready=0; grant -> IDLE, next op accepted.
//  4 Flush during EXEC cycle 2 -> IDLE next edge, no cdb_valid, op_count unchanged; flush+grant -> no count.
//  5 rst asserted in WB -> all outputs at reset values next edge; issue_valid held during rst not accepted.
//  6 LATENCY=1 back-to-back with grant tied high -> one result every 3 cycles, op_count saturates at FFFF.

Source files
------------

// File: rtl/add_exec_pipe.sv
// Add/logic execution unit for the Tomasulo core.
// Takes one ready instruction from the add reservation stations and runs it
// for LATENCY cycles. It then holds the result on the CDB until the arbiter
// grants it. A flush kills the in-flight op. op_count is CNT_W bits wide and
// saturates at all-ones; the core uses the default width of 16.
module add_exec_pipe #(
    parameter int DATA_W  = 8,
    parameter int RES_W   = 16,
    parameter int ROB_W   = 3,
    parameter int RS_W    = 3,
    parameter int REG_W   = 4,
    parameter int LATENCY = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [3:0]        func,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic [ROB_W-1:0]  rob_ind,
    input  logic [RS_W-1:0]   rs_index,
    input  logic [REG_W-1:0]  rd,
    input  logic              flush,
    output logic              cdb_valid,
    input  logic              cdb_grant,
    output logic [RES_W-1:0]  cdb_data,
    output logic [ROB_W-1:0]  cdb_rob,
    output logic [REG_W-1:0]  cdb_rd,
    output logic [RS_W-1:0]   cdb_rs,
    output logic              cdb_illegal,
    output logic [CNT_W-1:0]  op_count
);

    // state | meaning
    // IDLE  | free, accepts an issue this cycle
    // EXEC  | operands latched, counting execute cycles
    // WB    | result on CDB, waiting for grant
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [3:0]         func_q;
    logic [DATA_W-1:0]  a_q, b_q;
    logic [ROB_W-1:0]   rob_q;
    logic [RS_W-1:0]    rs_q;
    logic [REG_W-1:0]   rd_q;
    logic [RES_W-1:0]   cdb_data_q;
    logic [ROB_W-1:0]   cdb_rob_q;
    logic [REG_W-1:0]   cdb_rd_q;
    logic [RS_W-1:0]    cdb_rs_q;
    logic               cdb_ill_q;
    logic [CNT_W-1:0]   op_count_q;

    logic [DATA_W:0]    sum_w, diff_w;
    logic               slt_w;
    logic [RES_W-1:0]   res_d;
    logic               ill_d;
    logic               accept, exec_done, wb_load, grant_ok;

    assign accept    = (state_q == S_IDLE) && issue_valid && !flush;
    assign exec_done = (state_q == S_EXEC) && (cnt_q == LAST);
    // A flush on the last execute edge must not let the result reach the bus.
    assign wb_load   = exec_done && !flush;
    assign grant_ok  = (state_q == S_WB) && cdb_grant && !flush;

    // State register.
    always_ff @(posedge clk1) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic. Flush returns to IDLE from any state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (issue_valid) state_d = S_EXEC;
            S_EXEC:  if (cnt_q == LAST) state_d = S_WB;
            S_WB:    if (cdb_grant) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // Handshake outputs come straight from the registered state.
    always_comb begin
        issue_ready = (state_q == S_IDLE);
        cdb_valid   = (state_q == S_WB);
    end

    // Result of the latched op. Sub is a (DATA_W+1)-bit difference, sign-extended.
    always_comb begin
        sum_w  = {1'b0, a_q} + {1'b0, b_q};
        diff_w = {1'b0, a_q} - {1'b0, b_q};
        slt_w  = $signed(a_q) < $signed(b_q);
        res_d  = '0;
        ill_d  = 1'b0;
        case (func_q)
            4'h0:    res_d = RES_W'(sum_w);
            4'h1:    res_d = RES_W'($signed(diff_w));
            4'h2:    res_d = RES_W'(a_q & b_q);
            4'h3:    res_d = RES_W'(a_q | b_q);
            4'h4:    res_d = RES_W'(a_q ^ b_q);
            4'h5:    res_d = RES_W'(slt_w);
            default: ill_d = 1'b1;
        endcase
    end

    // Operand and tag capture on accept, plus the execute cycle counter.
    always_ff @(posedge clk1) begin
        if (rst) begin
            cnt_q  <= '0;
            func_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            rob_q  <= '0;
            rs_q   <= '0;
            rd_q   <= '0;
        end else if (accept) begin
            cnt_q  <= '0;
            func_q <= func;
            a_q    <= rs1_data;
            b_q    <= rs2_data;
            rob_q  <= rob_ind;
            rs_q   <= rs_index;
            rd_q   <= rd;
        end else if ((state_q == S_EXEC) && (cnt_q != LAST)) begin
            cnt_q  <= cnt_q + CW'(1);
        end
    end

    // CDB payload is loaded only when entering WB, so it stays stable through a stall.
    always_ff @(posedge clk1) begin
        if (rst) begin
            cdb_data_q <= '0;
            cdb_rob_q  <= '0;
            cdb_rd_q   <= '0;
            cdb_rs_q   <= '0;
            cdb_ill_q  <= 1'b0;
        end else if (wb_load) begin
            cdb_data_q <= res_d;
            cdb_rob_q  <= rob_q;
            cdb_rd_q   <= rd_q;
            cdb_rs_q   <= rs_q;
            cdb_ill_q  <= ill_d;
        end
    end

    // Saturating count of granted broadcasts. A flush cancels the grant.
    always_ff @(posedge clk1) begin
        if (rst)                                   op_count_q <= '0;
        else if (grant_ok && (op_count_q != '1))   op_count_q <= op_count_q + CNT_W'(1);
    end

    assign cdb_data    = cdb_data_q;
    assign cdb_rob     = cdb_rob_q;
    assign cdb_rd      = cdb_rd_q;
    assign cdb_rs      = cdb_rs_q;
    assign cdb_illegal = cdb_ill_q;
    assign op_count    = op_count_q;

endmodule
